// File: rtl/shared_reg_pkg.sv
// Shared types and constants for the shared-register arbiter.
package shared_reg_pkg;

  typedef enum logic {
    OP_INC  = 1'b0,
    OP_LOAD = 1'b1
  } op_e;

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int UPD_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin scheduler serialising INC/LOAD updates of one shared register.
// state  | meaning
// OPEN   | rotating-priority grant across all valid requesters, starting at ptr
// LOCKED | only the owner may transfer; owner dropping valid releases the lock
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int               N_REQ = 4,
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_op,
  input  logic [N_REQ-1:0][WIDTH-1:0]       req_data,
  input  logic [N_REQ-1:0]                  req_lock,
  output logic [N_REQ-1:0]                  req_ready,
  output logic [WIDTH-1:0]                  value,
  output logic [WIDTH-1:0]                  snap,
  output logic                              locked,
  output logic [$clog2(N_REQ)-1:0]          owner,
  output logic [UPD_CNT_W-1:0]              upd_count
);

  localparam int IW = $clog2(N_REQ);

  state_e          state;
  state_e          state_nxt;
  logic [IW-1:0]   ptr;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            gany;
  logic            xfer;

  // LOCKED reuses the same picker with everything but the owner masked off
  assign elig = (state == LOCKED) ? (req_valid & (N_REQ'(1) << owner)) : req_valid;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign xfer = gany & ~rst;

  always_ff @(posedge clk) begin
    if (rst) state <= OPEN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OPEN: begin
        if (xfer && req_lock[gidx]) state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!req_valid[owner])              state_nxt = OPEN;
        else if (xfer && !req_lock[gidx])   state_nxt = OPEN;
      end
      default: state_nxt = OPEN;
    endcase
  end

  always_comb begin
    req_ready = rst ? '0 : gnt;
    locked    = (state == LOCKED);
  end

  // ptr is only advanced by a grant, so a lock release already leaves it at owner+1
  always_ff @(posedge clk) begin
    if (rst) begin
      value     <= INIT;
      snap      <= '0;
      ptr       <= '0;
      owner     <= '0;
      upd_count <= '0;
    end else if (xfer) begin
      value     <= (op_e'(req_op[gidx]) == OP_LOAD) ? req_data[gidx] : value + 1'b1;
      snap      <= value;
      upd_count <= upd_count + 1'b1;
      owner     <= gidx;
      ptr       <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin scheduler that shares one WIDTH-bit state register between N_REQ requesting processes. Every update to the register is serialized and applied with nonblocking semantics at a single clock edge, so the result never depends on process execution order. The block replaces ad-hoc multi-writer `always @(posedge clk)` updates of a shared variable. It sits between requester processes and any reader that samples the register's value or its pre-update snapshot.

## Interface
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, width of shared register
- INIT, 1, reset value of the shared register
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has a pending operation
- req_op  in  N_REQ x 1  per-requester op: 0 = INC, 1 = LOAD
- req_data  in  N_REQ x WIDTH  LOAD operand (ignored for INC)
- req_lock  in  N_REQ  requester wants to keep ownership after this transfer
- req_ready  out  N_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i]
- value  out  WIDTH  current shared register
- snap  out  WIDTH  value as it was immediately before the most recent update
- locked  out  1  high while in LOCKED state
- owner  out  $clog2(N_REQ)  index of the last granted requester
- upd_count  out  16  number of accepted transfers, wraps at 2^16

## Operation
- Synchronous reset: value = INIT, snap = 0, ptr = 0, owner = 0, upd_count = 0, state = OPEN. req_ready is all zero during a reset cycle.
- State OPEN: the grant goes to the first i with req_valid[i], searching ptr, ptr+1, ... mod N_REQ. No valid requester means req_ready = 0.
- State LOCKED: only the owner is eligible. req_ready[owner] = req_valid[owner]. All others see 0.
- On an accepted transfer by requester g:
  - value <= (op INC) ? value + 1 (mod 2^WIDTH) : req_data[g]
  - snap <= old value
  - upd_count <= upd_count + 1
  - owner <= g
  - ptr <= (g + 1) mod N_REQ
- Transitions:
  - OPEN -> LOCKED on an accepted transfer with req_lock[g] = 1.
  - LOCKED -> OPEN on an accepted owner transfer with req_lock = 0.
  - LOCKED -> OPEN on any cycle where req_valid[owner] = 0 (owner released). A release cycle grants nobody.
- A LOCKED -> OPEN exit leaves ptr = owner+1, so the former owner is serviced last.
- Simultaneous requests from all N_REQ: exactly one grant per cycle. Each requester is served within N_REQ cycles in OPEN.
- Reset asserted mid-LOCKED: forces OPEN and INIT. The in-flight transfer that cycle is discarded.
- LOAD with data equal to value still counts as an update: snap and upd_count change.

## Timing
- req_ready is combinational from req_valid, state, ptr and owner. There is no combinational path from req_data or req_op to req_ready.
- value, snap, owner and upd_count reflect a transfer at cycle t from cycle t+1 (latency 1).
- Throughput is one transfer per cycle.
- ptr wrap: grant of N_REQ-1 sets ptr = 0.
- value wrap: INC of 2^WIDTH-1 gives 0.

## Structure
- Package shared_reg_pkg holds:
  - op_e enum (OP_INC = 1'b0, OP_LOAD = 1'b1)
  - state_e enum (OPEN, LOCKED)
  - the UPD_CNT_W = 16 constant
- Sub-module rr_pick holds the rotating-priority one-hot picker. Inputs: req vector, ptr. Outputs: one-hot grant, index, any. It is purely combinational and reused in LOCKED with a masked request vector.
- Top level holds the FSM, ptr, and datapath registers.

## Test plan
- Reset then idle: value = 1, snap = 0, upd_count = 0, req_ready = 0 for 5 cycles.
- All four requesters INC continuously from reset: grants go 0,1,2,3,0. After 4 edges value = 5, snap = 4, upd_count = 4.
- Requester 2 LOADs 8'hFF with lock, then INCs with lock=1 while requesters 0 and 1 are valid:
  - only 2 is granted; value goes FF -> 00, snap = FF.
  - 2 then issues lock=0; the next grant goes to 3 if valid, else 0.
- Owner 1 drops req_valid while LOCKED: there is one cycle with no grant and locked falls. The next cycle grants requester 2, or wraps to the first valid after it.
- Assert rst during LOCKED with a transfer pending: the next cycle shows value = INIT, locked = 0, upd_count = 0, and no update applied.
- Determinism check: two benches stimulate requesters in different process orders and must produce identical value/snap traces over 100 random cycles.
